// File: rtl/sap_ctrl_pkg.sv
// SAP control sequencer shared types.
// Opcodes, FSM states, control word layout, T-state indices.
package sap_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int NT = 6;
  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    HALT
  } state_t;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

endpackage

// File: rtl/sap_control_sequencer_if.sv
// SAP control sequencer bus bundle.
// master drives run/step/opcode; slave drives ring and control word.
interface sap_control_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             run;
  logic             step;
  logic [3:0]       opcode;
  logic [5:0]       T;
  logic             CP, EP, LM, CE, LI, EI;
  logic             LA, EA, SU, EU, LB, LO;
  logic             LDA, ADD, SUB, OUT, HLT, NOP;
  logic             halted;
  logic             instr_done;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output run, step, opcode,
    input  T, CP, EP, LM, CE, LI, EI,
    input  LA, EA, SU, EU, LB, LO,
    input  LDA, ADD, SUB, OUT, HLT, NOP,
    input  halted, instr_done, instr_cnt
  );

  modport slave (
    input  run, step, opcode,
    output T, CP, EP, LM, CE, LI, EI,
    output LA, EA, SU, EU, LB, LO,
    output LDA, ADD, SUB, OUT, HLT, NOP,
    output halted, instr_done, instr_cnt
  );
endinterface

// File: rtl/sap_ring_counter.sv
// One-hot T1..T6 ring with async clear,
// sync clear, sync restart-to-T1 and shift enable.
module sap_ring_counter
  import sap_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic          i_restart,
  input  logic          i_clr,
  output logic [NT-1:0] o_t
);

  logic [NT-1:0] r_t;

  // clear wins over restart, restart over rotate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t <= '0;
    end else if (i_clr) begin
      r_t <= '0;
    end else if (i_restart) begin
      r_t     <= '0;
      r_t[T1] <= 1'b1;
    end else if (i_en) begin
      r_t <= {r_t[NT-2:0], r_t[NT-1]};
    end
  end

  assign o_t = r_t;

endmodule

// File: rtl/sap_control_sequencer.sv
// SAP hardwired control unit: FSM, step edge detect,
// opcode decode, control word table, retired counter.
module sap_control_sequencer
  import sap_ctrl_pkg::*;
#(
  parameter bit EARLY_END = 1'b0,
  parameter int CNT_W     = 8
) (
  input logic                   clk,
  input logic                   rst,
  sap_control_sequencer_if.slave bus
);

  state_t           r_state;
  state_t           w_next;
  logic             r_step_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_step_edge;
  logic             w_go;
  logic             w_last;
  logic [NT-1:0]    w_t;
  logic [NT-1:0]    w_last_mask;
  ctrl_word_t       w_cw;
  logic             w_lda, w_add, w_sub;
  logic             w_out, w_hlt, w_nop;

  assign w_lda = bus.opcode == OP_LDA;
  assign w_add = bus.opcode == OP_ADD;
  assign w_sub = bus.opcode == OP_SUB;
  assign w_out = bus.opcode == OP_OUT;
  assign w_hlt = bus.opcode == OP_HLT;
  assign w_nop = ~(w_lda | w_add | w_sub | w_out | w_hlt);

  assign w_step_edge = bus.step & ~r_step_d;
  assign w_go        = bus.run | w_step_edge;

  // final T-state of the current instruction
  always_comb begin
    w_last_mask = '0;
    if (w_hlt) begin
      w_last_mask[T4] = 1'b1;
    end else if (!EARLY_END) begin
      w_last_mask[T6] = 1'b1;
    end else begin
      unique case (1'b1)
        w_lda:         w_last_mask[T5] = 1'b1;
        w_add | w_sub: w_last_mask[T6] = 1'b1;
        w_out:         w_last_mask[T4] = 1'b1;
        default:       w_last_mask[T3] = 1'b1;
      endcase
    end
  end

  assign w_last = (r_state == EXEC) && |(w_t & w_last_mask);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  // next state
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_go) w_next = EXEC;
      EXEC: begin
        if (w_last) begin
          if (w_hlt)     w_next = HALT;
          else if (w_go) w_next = EXEC;
          else           w_next = IDLE;
        end
      end
      HALT:    w_next = HALT;
      default: w_next = IDLE;
    endcase
  end

  sap_ring_counter u_ring (
    .clk       (clk),
    .rst_n     (rst),
    .i_en      (r_state == EXEC),
    .i_restart ((w_next == EXEC) &&
                ((r_state != EXEC) || w_last)),
    .i_clr     (w_next != EXEC),
    .o_t       (w_t)
  );

  // control word per T-state and opcode
  always_comb begin
    w_cw = '0;
    if (r_state == EXEC) begin
      unique case (1'b1)
        w_t[T1]: begin
          w_cw.ep = 1'b1;
          w_cw.lm = 1'b1;
        end
        w_t[T2]: w_cw.cp = 1'b1;
        w_t[T3]: begin
          w_cw.ce = 1'b1;
          w_cw.li = 1'b1;
        end
        w_t[T4]: begin
          if (w_lda | w_add | w_sub) begin
            w_cw.ei = 1'b1;
            w_cw.lm = 1'b1;
          end else if (w_out) begin
            w_cw.ea = 1'b1;
            w_cw.lo = 1'b1;
          end
        end
        w_t[T5]: begin
          if (w_lda) begin
            w_cw.ce = 1'b1;
            w_cw.la = 1'b1;
          end else if (w_add | w_sub) begin
            w_cw.ce = 1'b1;
            w_cw.lb = 1'b1;
          end
        end
        w_t[T6]: begin
          if (w_add | w_sub) begin
            w_cw.eu = 1'b1;
            w_cw.la = 1'b1;
            w_cw.su = w_sub;
          end
        end
        default: w_cw = '0;
      endcase
    end
  end

  // step edge detector
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_step_d <= 1'b0;
    else      r_step_d <= bus.step;
  end

  // retired instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_cnt <= '0;
    else if (w_last) r_cnt <= r_cnt + 1'b1;
  end

  assign bus.T          = w_t;
  assign bus.CP         = w_cw.cp;
  assign bus.EP         = w_cw.ep;
  assign bus.LM         = w_cw.lm;
  assign bus.CE         = w_cw.ce;
  assign bus.LI         = w_cw.li;
  assign bus.EI         = w_cw.ei;
  assign bus.LA         = w_cw.la;
  assign bus.EA         = w_cw.ea;
  assign bus.SU         = w_cw.su;
  assign bus.EU         = w_cw.eu;
  assign bus.LB         = w_cw.lb;
  assign bus.LO         = w_cw.lo;
  assign bus.LDA        = w_lda;
  assign bus.ADD        = w_add;
  assign bus.SUB        = w_sub;
  assign bus.OUT        = w_out;
  assign bus.HLT        = w_hlt;
  assign bus.NOP        = w_nop;
  assign bus.halted     = r_state == HALT;
  assign bus.instr_done = w_last;
  assign bus.instr_cnt  = r_cnt;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Bench for sap_control_sequencer: two instances
// (full-length/8-bit count and early-end/4-bit count).
module tb_sap_control_sequencer;

  localparam logic [11:0] B_CP = 12'h800;
  localparam logic [11:0] B_EP = 12'h400;
  localparam logic [11:0] B_LM = 12'h200;
  localparam logic [11:0] B_CE = 12'h100;
  localparam logic [11:0] B_LI = 12'h080;
  localparam logic [11:0] B_EI = 12'h040;
  localparam logic [11:0] B_LA = 12'h020;
  localparam logic [11:0] B_EA = 12'h010;
  localparam logic [11:0] B_SU = 12'h008;
  localparam logic [11:0] B_EU = 12'h004;
  localparam logic [11:0] B_LB = 12'h002;
  localparam logic [11:0] B_LO = 12'h001;

  logic clk = 1'b0;
  logic rst0, rst1;
  int   checks = 0;
  int   failures = 0;

  // model: ms 0=idle 1=exec 2=halt, mk = T index 1..6
  int ms[2], mk[2], mc[2];
  bit mp[2];

  sap_control_sequencer_if #(.CNT_W(8)) if0 ();
  sap_control_sequencer_if #(.CNT_W(4)) if1 ();

  sap_control_sequencer #(.EARLY_END(1'b0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst0), .bus(if0)
  );
  sap_control_sequencer #(.EARLY_END(1'b1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst1), .bus(if1)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int i, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h",
               nm, i, $time, a, e);
    end
  endtask

  function automatic int lastk(int ee, logic [3:0] op);
    if (op == 4'hF) return 4;
    if (ee == 0) return 6;
    case (op)
      4'h0:       return 5;
      4'h1, 4'h2: return 6;
      4'hE:       return 4;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [11:0] ecw(logic [3:0] op, int k);
    case (k)
      1: return B_EP | B_LM;
      2: return B_CP;
      3: return B_CE | B_LI;
      4: if (op <= 4'h2) return B_EI | B_LM;
         else if (op == 4'hE) return B_EA | B_LO;
      5: if (op == 4'h0) return B_CE | B_LA;
         else if (op <= 4'h2) return B_CE | B_LB;
      6: if (op == 4'h1) return B_EU | B_LA;
         else if (op == 4'h2) return B_SU | B_EU | B_LA;
      default: ;
    endcase
    return 12'h000;
  endfunction

  task automatic mrst(int i);
    ms[i] = 0; mk[i] = 0; mc[i] = 0; mp[i] = 1'b0;
  endtask

  task automatic mupd(int i, int ee, int w, logic run,
                      logic step, logic [3:0] op);
    bit go;
    go = run || (step && !mp[i]);
    mp[i] = step;
    if (ms[i] == 0) begin
      if (go) begin ms[i] = 1; mk[i] = 1; end
    end else if (ms[i] == 1) begin
      if (mk[i] == lastk(ee, op)) begin
        mc[i] = (mc[i] + 1) % (1 << w);
        if (op == 4'hF) begin ms[i] = 2; mk[i] = 0; end
        else if (go) mk[i] = 1;
        else begin ms[i] = 0; mk[i] = 0; end
      end else begin
        mk[i] = mk[i] + 1;
      end
    end
  endtask

  task automatic cmp(int i, int ee, logic [5:0] t, logic [11:0] ctl,
                     logic [5:0] dec, logic h, logic d,
                     logic [7:0] cnt, logic [3:0] op);
    logic [5:0] et, ed;
    logic ex;
    ex = ms[i] == 1;
    et = ex ? 6'(1 << (mk[i] - 1)) : 6'd0;
    ed = {op == 4'h0, op == 4'h1, op == 4'h2, op == 4'hE, op == 4'hF,
          !(op <= 4'h2 || op >= 4'hE)};
    chk("ring", i, 32'(t), 32'(et));
    chk("ctrl", i, 32'(ctl), ex ? 32'(ecw(op, mk[i])) : 32'd0);
    chk("decode", i, 32'(dec), 32'(ed));
    chk("halted", i, 32'(h), 32'(ms[i] == 2));
    chk("done", i, 32'(d), 32'(ex && mk[i] == lastk(ee, op)));
    chk("cnt", i, 32'(cnt), 32'(mc[i]));
    chk("bus_onehot", i,
        32'($onehot0({ctl[10], ctl[8], ctl[6], ctl[4], ctl[2]})), 32'd1);
  endtask

  function automatic logic [11:0] cw0();
    return {if0.CP, if0.EP, if0.LM, if0.CE, if0.LI, if0.EI,
            if0.LA, if0.EA, if0.SU, if0.EU, if0.LB, if0.LO};
  endfunction

  function automatic logic [11:0] cw1();
    return {if1.CP, if1.EP, if1.LM, if1.CE, if1.LI, if1.EI,
            if1.LA, if1.EA, if1.SU, if1.EU, if1.LB, if1.LO};
  endfunction

  function automatic logic [5:0] tv(int i);
    return (i == 0) ? if0.T : if1.T;
  endfunction

  // model for instance 0
  always @(posedge clk or negedge rst0) begin
    if (!rst0) mrst(0);
    else mupd(0, 0, 8, if0.run, if0.step, if0.opcode);
  end

  // model for instance 1
  always @(posedge clk or negedge rst1) begin
    if (!rst1) mrst(1);
    else mupd(1, 1, 4, if1.run, if1.step, if1.opcode);
  end

  // per-cycle compare, just before the rising edge
  always @(negedge clk) begin
    #3;
    if (rst0)
      cmp(0, 0, if0.T, cw0(),
          {if0.LDA, if0.ADD, if0.SUB, if0.OUT, if0.HLT, if0.NOP},
          if0.halted, if0.instr_done, if0.instr_cnt, if0.opcode);
    if (rst1)
      cmp(1, 1, if1.T, cw1(),
          {if1.LDA, if1.ADD, if1.SUB, if1.OUT, if1.HLT, if1.NOP},
          if1.halted, if1.instr_done, {4'd0, if1.instr_cnt}, if1.opcode);
  end

  task automatic wait_t(int i, int b, string nm);
    logic [5:0] t;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk);
      #1;
      t = tv(i);
      if (t[b]) return;
    end
    checks++;
    failures++;
    $display("FAIL timeout_%s dut%0d actual=T%0d_not_seen required=T%0d",
             nm, i, b + 1, b + 1);
  endtask

  initial begin
    int n;
    rst0 = 1'b0; rst1 = 1'b0;
    if0.run = 1'b1; if0.step = 1'b0; if0.opcode = 4'h0;
    if1.run = 1'b0; if1.step = 1'b0; if1.opcode = 4'h0;
    repeat (2) @(negedge clk);
    chk("rst_T", 0, 32'(if0.T), 0);
    chk("rst_ctrl", 0, 32'(cw0()), 0);
    chk("rst_halted", 0, 32'(if0.halted), 0);
    chk("rst_cnt", 1, 32'(if1.instr_cnt), 0);
    rst0 = 1'b1;

    // LDA ring sequence
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      chk("lda_seq", 0, 32'(if0.T), 32'(6'd1 << (i % 6)));
      if (i == 0) chk("lda_t1", 0, 32'(cw0()), 32'h600);
      if (i == 4) chk("lda_t5", 0, 32'(cw0()), 32'h120);
      if (i == 6) chk("lda_cnt", 0, 32'(if0.instr_cnt), 1);
    end

    // SUB then ADD at T6
    @(negedge clk) if0.opcode = 4'h2;
    wait_t(0, 5, "sub");
    chk("sub_t6", 0, 32'(cw0()), 32'h02C);
    wait_t(0, 0, "sub_end");
    @(negedge clk) if0.opcode = 4'h1;
    wait_t(0, 5, "add");
    chk("add_t6", 0, 32'(cw0()), 32'h024);
    chk("add_su", 0, 32'(if0.SU), 0);

    // HLT, then stay halted
    wait_t(0, 0, "add_end");
    @(negedge clk) if0.opcode = 4'hF;
    wait_t(0, 3, "hlt");
    chk("hlt_t4", 0, 32'(cw0()), 0);
    chk("hlt_done", 0, 32'(if0.instr_done), 1);
    @(posedge clk);
    #1;
    chk("hlt_halted", 0, 32'(if0.halted), 1);
    chk("hlt_T", 0, 32'(if0.T), 0);
    for (int i = 0; i < 20; i++) @(negedge clk) if0.step = i[0];
    #1;
    chk("hlt_stay", 0, 32'(if0.halted), 1);
    chk("hlt_stayT", 0, 32'(if0.T), 0);
    chk("hlt_cnt", 0, 32'(if0.instr_cnt), 4);
    @(negedge clk) rst0 = 1'b0;
    #1;
    chk("hrst_halted", 0, 32'(if0.halted), 0);
    chk("hrst_cnt", 0, 32'(if0.instr_cnt), 0);
    if0.run = 1'b0; if0.step = 1'b0; if0.opcode = 4'h0;
    @(negedge clk) rst0 = 1'b1;

    // single step pulse
    @(negedge clk) if0.step = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) if0.step = 1'b0;
      if (|if0.T) n++;
    end
    chk("step_len", 0, 32'(n), 6);
    chk("step_idle", 0, 32'(if0.T), 0);
    chk("step_cnt", 0, 32'(if0.instr_cnt), 1);

    // step held high for 10 cycles
    @(negedge clk) if0.step = 1'b1;
    n = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk);
      #1;
      if (c == 9) if0.step = 1'b0;
      if (|if0.T) n++;
    end
    chk("held_len", 0, 32'(n), 6);
    chk("held_cnt", 0, 32'(if0.instr_cnt), 2);

    // async reset mid-T5
    @(negedge clk) if0.run = 1'b1;
    wait_t(0, 4, "t5");
    #2 rst0 = 1'b0;
    #1;
    chk("arst_T", 0, 32'(if0.T), 0);
    chk("arst_ctrl", 0, 32'(cw0()), 0);
    chk("arst_cnt", 0, 32'(if0.instr_cnt), 0);
    @(negedge clk) if0.run = 1'b0;
    @(negedge clk) rst0 = 1'b1;

    // early end: OUT then NOP
    @(negedge clk);
    if1.opcode = 4'hE; if1.run = 1'b1; rst1 = 1'b1;
    wait_t(1, 3, "out");
    chk("out_t4", 1, 32'(cw1()), 32'h011);
    chk("out_done", 1, 32'(if1.instr_done), 1);
    @(posedge clk);
    #1;
    chk("out_next", 1, 32'(if1.T), 1);
    @(negedge clk) if1.opcode = 4'h5;
    wait_t(1, 2, "nop");
    chk("nop_done", 1, 32'(if1.instr_done), 1);
    @(posedge clk);
    #1;
    chk("nop_next", 1, 32'(if1.T), 1);

    // 17 NOPs wrap a 4-bit counter to 1
    @(negedge clk) rst1 = 1'b0;
    @(negedge clk) rst1 = 1'b1;
    n = 0;
    for (int c = 0; c < 100 && n < 17; c++) begin
      @(negedge clk);
      #1;
      if (if1.instr_done) n++;
      if (n == 17) if1.run = 1'b0;
    end
    if (n < 17) begin
      checks++;
      failures++;
      $display("FAIL nop17_timeout dut1 actual=%0d required=17", n);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("wrap_cnt", 1, 32'(if1.instr_cnt), 1);
    chk("wrap_idle", 1, 32'(if1.T), 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
